// File: rtl/task_seq_pkg.sv
// rtl/task_seq_pkg.sv - shared state encoding and default constants for the task sequencer
package task_seq_pkg;

    localparam int          TASK_ID_W          = 5;
    localparam logic [31:0] DEF_TASK_MASK      = 32'h0000_00FF;
    localparam int          DEF_TIMEOUT_CYCLES = 1_000_000;

    typedef enum logic [3:0] {
        PUB_MASK,
        PUB_READY,
        IDLE,
        CHECK,
        START,
        RUN,
        REPORT,
        WAIT_ACK,
        CLR_OUT
    } seq_state_t;

endpackage

// File: rtl/task_seq_watchdog.sv
// rtl/task_seq_watchdog.sv - per-task cycle counter, cleared outside RUN, flags expiry at TIMEOUT_CYCLES-1
module task_seq_watchdog
    import task_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Holds at the limit so expiry stays visible until the FSM leaves RUN.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = run && (count == LIMIT);

endmodule

// File: rtl/task_sequencer.sv
// rtl/task_sequencer.sv - register-handshake task sequencer; optional watchdog under TASK_SEQ_TIMEOUT_EN
module task_sequencer
    import task_seq_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] TASK_MASK      = DATA_WIDTH'(DEF_TASK_MASK),
    parameter int                    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_soft_rst,
    input  logic                  i_tv_in_ready,
    input  logic [DATA_WIDTH-1:0] i_current_task,
    input  logic                  i_reg_wr_busy,
    output logic                  o_pl_ready,
    output logic                  o_pl_ready_wr_en,
    output logic [DATA_WIDTH-1:0] o_enabled_tasks,
    output logic                  o_enabled_tasks_wr_en,
    output logic                  o_tv_out_ready,
    output logic                  o_tv_out_ready_wr_en,
    output logic                  o_task_start,
    output logic [TASK_ID_W-1:0]  o_task_id,
    input  logic                  i_task_done,
    output logic                  o_task_abort,
    output logic                  o_err_invalid,
    output logic                  o_err_timeout
);

    seq_state_t state, state_nxt;

    logic                  any_rst;
    logic                  tv_prev;
    logic                  wr_pend, wr_pend_nxt;
    logic                  wr_fire;
    logic                  task_valid;
    logic [DATA_WIDTH-1:0] mask_shift;
    logic                  wd_expired;

    logic [DATA_WIDTH-1:0] enabled_tasks_nxt;
    logic                  pl_ready_nxt;
    logic                  tv_out_ready_nxt;
    logic [TASK_ID_W-1:0]  task_id_nxt;
    logic                  err_invalid_nxt;
    logic                  err_timeout_nxt;

    assign any_rst    = i_rst | i_soft_rst;
    assign mask_shift = TASK_MASK >> i_current_task;
    assign task_valid = (i_current_task < DATA_WIDTH'(DATA_WIDTH)) && mask_shift[0];

    // Each write state first loads its value (wr_pend=0), then fires the strobe
    // in the first non-busy cycle while the value register stays untouched.
    assign wr_fire = wr_pend && !i_reg_wr_busy;

`ifdef TASK_SEQ_TIMEOUT_EN
    task_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (i_clk),
        .rst    (any_rst),
        .run    (state == RUN),
        .expired(wd_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign wd_expired         = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (any_rst) begin
            state           <= PUB_MASK;
            wr_pend         <= 1'b0;
            o_enabled_tasks <= '0;
            o_pl_ready      <= 1'b0;
            o_tv_out_ready  <= 1'b0;
            o_task_id       <= '0;
            o_err_invalid   <= 1'b0;
            o_err_timeout   <= 1'b0;
            // A level already high when reset ends must not look like an edge.
            tv_prev         <= i_tv_in_ready;
        end else begin
            state           <= state_nxt;
            wr_pend         <= wr_pend_nxt;
            o_enabled_tasks <= enabled_tasks_nxt;
            o_pl_ready      <= pl_ready_nxt;
            o_tv_out_ready  <= tv_out_ready_nxt;
            o_task_id       <= task_id_nxt;
            o_err_invalid   <= err_invalid_nxt;
            o_err_timeout   <= err_timeout_nxt;
            tv_prev         <= i_tv_in_ready;
        end
    end

    always_comb begin
        state_nxt             = state;
        wr_pend_nxt           = wr_pend;
        enabled_tasks_nxt     = o_enabled_tasks;
        pl_ready_nxt          = o_pl_ready;
        tv_out_ready_nxt      = o_tv_out_ready;
        task_id_nxt           = o_task_id;
        err_invalid_nxt       = o_err_invalid;
        err_timeout_nxt       = o_err_timeout;
        o_enabled_tasks_wr_en = 1'b0;
        o_pl_ready_wr_en      = 1'b0;
        o_tv_out_ready_wr_en  = 1'b0;
        o_task_start          = 1'b0;
        o_task_abort          = 1'b0;

        case (state)
            PUB_MASK: begin
                if (!wr_pend) begin
                    enabled_tasks_nxt = TASK_MASK;
                    wr_pend_nxt       = 1'b1;
                end else if (wr_fire) begin
                    o_enabled_tasks_wr_en = 1'b1;
                    wr_pend_nxt           = 1'b0;
                    state_nxt             = PUB_READY;
                end
            end
            PUB_READY: begin
                if (!wr_pend) begin
                    pl_ready_nxt = 1'b1;
                    wr_pend_nxt  = 1'b1;
                end else if (wr_fire) begin
                    o_pl_ready_wr_en = 1'b1;
                    wr_pend_nxt      = 1'b0;
                    state_nxt        = IDLE;
                end
            end
            IDLE: begin
                if (i_tv_in_ready && !tv_prev) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (task_valid) begin
                    task_id_nxt = i_current_task[TASK_ID_W-1:0];
                    state_nxt   = START;
                end else begin
                    err_invalid_nxt = 1'b1;
                    state_nxt       = REPORT;
                end
            end
            START: begin
                o_task_start = 1'b1;
                state_nxt    = RUN;
            end
            RUN: begin
                if (i_task_done) begin
                    state_nxt = REPORT;
                end else if (wd_expired) begin
                    o_task_abort    = 1'b1;
                    err_timeout_nxt = 1'b1;
                    state_nxt       = REPORT;
                end
            end
            REPORT: begin
                if (!wr_pend) begin
                    tv_out_ready_nxt = 1'b1;
                    wr_pend_nxt      = 1'b1;
                end else if (wr_fire) begin
                    o_tv_out_ready_wr_en = 1'b1;
                    wr_pend_nxt          = 1'b0;
                    state_nxt            = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!i_tv_in_ready) begin
                    state_nxt = CLR_OUT;
                end
            end
            CLR_OUT: begin
                if (!wr_pend) begin
                    tv_out_ready_nxt = 1'b0;
                    wr_pend_nxt      = 1'b1;
                end else if (wr_fire) begin
                    o_tv_out_ready_wr_en = 1'b1;
                    wr_pend_nxt          = 1'b0;
                    state_nxt            = IDLE;
                end
            end
            default: begin
                state_nxt   = PUB_MASK;
                wr_pend_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_task_sequencer.sv
// tb/tb_task_sequencer.sv - directed self-checking bench for task_sequencer
module tb_task_sequencer;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_soft_rst = 1'b0;
    logic        tv = 1'b0;
    logic [31:0] cur_task = '0;
    logic        busy = 1'b0;
    logic        done = 1'b0;

    logic        o_pl_ready, o_pl_ready_wr_en;
    logic [31:0] o_enabled_tasks;
    logic        o_enabled_tasks_wr_en;
    logic        o_tv_out_ready, o_tv_out_ready_wr_en;
    logic        o_task_start;
    logic [4:0]  o_task_id;
    logic        o_task_abort, o_err_invalid, o_err_timeout;

    int checks = 0;
    int failures = 0;

    task_sequencer #(
        .DATA_WIDTH    (32),
        .TASK_MASK     (32'h0000_00FF),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk                (clk),
        .i_rst                (i_rst),
        .i_soft_rst           (i_soft_rst),
        .i_tv_in_ready        (tv),
        .i_current_task       (cur_task),
        .i_reg_wr_busy        (busy),
        .o_pl_ready           (o_pl_ready),
        .o_pl_ready_wr_en     (o_pl_ready_wr_en),
        .o_enabled_tasks      (o_enabled_tasks),
        .o_enabled_tasks_wr_en(o_enabled_tasks_wr_en),
        .o_tv_out_ready       (o_tv_out_ready),
        .o_tv_out_ready_wr_en (o_tv_out_ready_wr_en),
        .o_task_start         (o_task_start),
        .o_task_id            (o_task_id),
        .i_task_done          (done),
        .o_task_abort         (o_task_abort),
        .o_err_invalid        (o_err_invalid),
        .o_err_timeout        (o_err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [45:0] all_outs();
        return {o_pl_ready, o_pl_ready_wr_en, o_enabled_tasks, o_enabled_tasks_wr_en,
                o_tv_out_ready, o_tv_out_ready_wr_en, o_task_start, o_task_id,
                o_task_abort, o_err_invalid, o_err_timeout};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_publish(output bit mask_ok, output bit ready_ok);
        mask_ok  = 1'b0;
        ready_ok = 1'b0;
        for (int n = 0; n < 20 && !ready_ok; n++) begin
            if (o_enabled_tasks_wr_en && o_enabled_tasks == 32'hFF) mask_ok = 1'b1;
            if (o_pl_ready_wr_en && o_pl_ready && mask_ok) ready_ok = 1'b1;
            tick();
        end
    endtask

    task automatic wait_tv_wr(output bit seen, output bit val, output bit start_seen);
        seen       = 1'b0;
        val        = 1'b0;
        start_seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (o_task_start) start_seen = 1'b1;
            if (o_tv_out_ready_wr_en) begin
                seen = 1'b1;
                val  = o_tv_out_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (all_outs() !== 46'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
    endtask

    task automatic test_publish();
        bit m, r;
        i_rst = 1'b0;
        wait_publish(m, r);
        checks++;
        if (!m) begin failures++; $display("FAIL publish_mask got=0 exp=1 (0xFF write)"); end
        checks++;
        if (!r) begin failures++; $display("FAIL publish_ready got=0 exp=1"); end
        checks++;
        if (o_pl_ready !== 1'b1 || o_enabled_tasks !== 32'hFF) begin
            failures++;
            $display("FAIL publish_values got=%b/%h exp=1/000000ff", o_pl_ready, o_enabled_tasks);
        end
        repeat (2) tick();
    endtask

    task automatic test_busy_hold();
        bit m, r;
        bit strobe_seen;
        i_rst = 1'b1;
        busy  = 1'b1;
        repeat (2) tick();
        i_rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            strobe_seen = o_enabled_tasks_wr_en | o_pl_ready_wr_en | o_tv_out_ready_wr_en;
            checks++;
            if (strobe_seen !== 1'b0) begin
                failures++;
                $display("FAIL busy_no_strobe cycle=%0d got=1 exp=0", c);
            end
        end
        busy = 1'b0;
        #1;
        checks++;
        if (o_enabled_tasks_wr_en !== 1'b1 || o_enabled_tasks !== 32'hFF) begin
            failures++;
            $display("FAIL busy_first_free got=%b/%h exp=1/000000ff", o_enabled_tasks_wr_en, o_enabled_tasks);
        end
        wait_publish(m, r);
        checks++;
        if (!r) begin failures++; $display("FAIL busy_publish_ready got=0 exp=1"); end
        repeat (2) tick();
    endtask

    task automatic test_done_ignored();
        bit any;
        any  = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (5) begin
            tick();
            if (o_tv_out_ready_wr_en || o_task_start) any = 1'b1;
        end
        checks++;
        if (any) begin failures++; $display("FAIL done_in_idle got=activity exp=none"); end
    endtask

    task automatic test_valid_task();
        bit seen, val, st;
        cur_task = 32'd3;
        tv       = 1'b1;
        tick();
        checks++;
        if (o_task_start !== 1'b0) begin failures++; $display("FAIL start_early got=1 exp=0"); end
        tick();
        checks++;
        if (o_task_start !== 1'b1 || o_task_id !== 5'd3) begin
            failures++;
            $display("FAIL start_k2 got=%b id=%0d exp=1 id=3", o_task_start, o_task_id);
        end
        tick();
        checks++;
        if (o_task_start !== 1'b0 || o_task_id !== 5'd3) begin
            failures++;
            $display("FAIL start_one_cycle got=%b id=%0d exp=0 id=3", o_task_start, o_task_id);
        end
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_tv_wr(seen, val, st);
        checks++;
        if (!seen || val !== 1'b1) begin
            failures++;
            $display("FAIL valid_report got=%b/%b exp=1/1", seen, val);
        end
        tv = 1'b0;
        wait_tv_wr(seen, val, st);
        checks++;
        if (!seen || val !== 1'b0) begin
            failures++;
            $display("FAIL valid_clear got=%b/%b exp=1/0", seen, val);
        end
        repeat (2) tick();
    endtask

    task automatic test_invalid();
        bit seen, val, st, m, r;
        cur_task = 32'd12;
        tv       = 1'b1;
        wait_tv_wr(seen, val, st);
        checks++;
        if (st || !seen || val !== 1'b1 || o_err_invalid !== 1'b1) begin
            failures++;
            $display("FAIL invalid_12 got=start%b wr%b val%b err%b exp=start0 wr1 val1 err1", st, seen, val, o_err_invalid);
        end
        tv = 1'b0;
        wait_tv_wr(seen, val, st);
        repeat (2) tick();
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        checks++;
        if (o_err_invalid !== 1'b0) begin failures++; $display("FAIL err_clear got=1 exp=0"); end
        wait_publish(m, r);
        tick();
        cur_task = 32'd40;
        tv       = 1'b1;
        wait_tv_wr(seen, val, st);
        checks++;
        if (st || !seen || val !== 1'b1 || o_err_invalid !== 1'b1) begin
            failures++;
            $display("FAIL invalid_40 got=start%b wr%b val%b err%b exp=start0 wr1 val1 err1", st, seen, val, o_err_invalid);
        end
        tv = 1'b0;
        wait_tv_wr(seen, val, st);
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        bit seen, val, st;
        int jj;
        cur_task = 32'd5;
        tv       = 1'b1;
        repeat (2) tick();
        checks++;
        if (o_task_start !== 1'b1) begin failures++; $display("FAIL to_start got=0 exp=1"); end
        jj = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (o_task_abort) begin
                jj = j;
                break;
            end
        end
`ifdef TASK_SEQ_TIMEOUT_EN
        checks++;
        if (jj != 16) begin failures++; $display("FAIL abort_cycle got=%0d exp=16", jj); end
        wait_tv_wr(seen, val, st);
        checks++;
        if (!seen || val !== 1'b1 || o_err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_report got=wr%b val%b err%b exp=1/1/1", seen, val, o_err_timeout);
        end
`else
        checks++;
        if (jj != 0 || o_err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL no_watchdog got=abort@%0d err%b exp=none err0", jj, o_err_timeout);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_tv_wr(seen, val, st);
        checks++;
        if (!seen || val !== 1'b1) begin failures++; $display("FAIL late_done_report got=%b/%b exp=1/1", seen, val); end
`endif
        tv = 1'b0;
        wait_tv_wr(seen, val, st);
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        bit seen, val, st;
        cur_task = 32'd6;
        tv       = 1'b1;
        repeat (3) tick();
        tv = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (o_tv_out_ready_wr_en) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL fall_in_run got=write exp=none"); end
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_tv_wr(seen, val, st);
        checks++;
        if (!seen || val !== 1'b1) begin failures++; $display("FAIL b2b_report got=%b/%b exp=1/1", seen, val); end
        wait_tv_wr(seen, val, st);
        checks++;
        if (!seen || val !== 1'b0) begin failures++; $display("FAIL b2b_clear got=%b/%b exp=1/0", seen, val); end
        tick();
        cur_task = 32'd7;
        tv       = 1'b1;
        repeat (2) tick();
        checks++;
        if (o_task_start !== 1'b1 || o_task_id !== 5'd7) begin
            failures++;
            $display("FAIL b2b_start got=%b id=%0d exp=1 id=7", o_task_start, o_task_id);
        end
    endtask

    task automatic test_soft_reset();
        bit m, r;
        repeat (2) tick();
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        checks++;
        if (all_outs() !== 46'h0) begin
            failures++;
            $display("FAIL soft_rst_outputs got=%h exp=0", all_outs());
        end
        wait_publish(m, r);
        checks++;
        if (!m || !r) begin failures++; $display("FAIL soft_rst_republish got=%b%b exp=11", m, r); end
        tv = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_publish();
        test_busy_hold();
        test_done_ignored();
        test_valid_task();
        test_invalid();
        test_timeout();
        test_back_to_back();
        test_soft_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
